// File: rtl/adc_frame_pkg.sv
// Shared definitions for the ADC sample framer: entry layout, frame byte
// layout and the serialiser state encoding.
package adc_frame_pkg;

  localparam int FRAME_BYTES = 3;
  localparam int SEQ_W       = 5;
  localparam int CH_W        = 3;
  localparam int SAMP_W      = 12;
  localparam int ENTRY_W     = SEQ_W + CH_W + SAMP_W;  // 20

  // Bit 7 marks the first byte of a frame; bit 6 of that byte is always 0.
  localparam int SYNC_BIT    = 7;
  localparam int HDR_BIT     = 6;

  // Field positions inside a buffered entry {seq, ch, data}
  localparam int DATA_LSB    = 0;
  localparam int CH_LSB      = SAMP_W;
  localparam int SEQ_LSB     = SAMP_W + CH_W;

  // One state per emitted byte plus IDLE; FRAME_BYTES states are non-idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2,
    ST_B2   = 2'd3
  } frame_state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [SEQ_W-1:0]  seq,
    input logic [CH_W-1:0]   ch,
    input logic [SAMP_W-1:0] data
  );
    return {seq, ch, data};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with a registered read port (rd_data updates on pop).
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module sample_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A write while full is legal only when a pop frees the slot on the same edge.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // Pointer state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage and registered read; when full, the read sees the old slot contents
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    if (do_rd) rd_data <= mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/adc_sample_framer.sv
// Buffers ADC samples and serialises each into a 3-byte self-synchronising
// frame on a valid/ready byte stream. The FIFO read register doubles as the
// holding register for the frame currently being sent.
module adc_sample_framer
  import adc_frame_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          samp_ready,
  input  logic [SAMP_W-1:0]             samp_data,
  input  logic [CH_W-1:0]               samp_ch,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic                          clr_stats,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              overflow_cnt
);

  frame_state_t         state, state_nxt;
  logic [SEQ_W-1:0]     seq;
  logic                 strobe;
  logic                 pop;
  logic                 wr_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   hold;
  logic [SAMP_W-1:0]    hold_data;
  logic [CH_W-1:0]      hold_ch;
  logic [SEQ_W-1:0]     hold_seq;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign strobe = samp_ready & enable;
  assign wr_en  = strobe & (~fifo_full | pop);

  assign hold_data = hold[DATA_LSB +: SAMP_W];
  assign hold_ch   = hold[CH_LSB   +: CH_W];
  assign hold_seq  = hold[SEQ_LSB  +: SEQ_W];

  assign tx_valid = (state != ST_IDLE);

  sample_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (pack_entry(seq, samp_ch, samp_data)),
    .rd_en   (pop),
    .rd_data (hold),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Sequence tag advances on every enabled strobe, accepted or dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       seq <= '0;
    else if (strobe) seq <= seq + 1'b1;
  end

  // Saturating drop counter; a clear request overrides a coincident drop
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 overflow_cnt <= '0;
    else if (clr_stats)        overflow_cnt <= '0;
    else if (strobe && !wr_en) overflow_cnt <= sat_inc(overflow_cnt);
  end

  // Serialiser state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, pop request and byte mux
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_data   = '0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_B0;
        end
      end
      ST_B0: begin
        tx_data           = {1'b1, 1'b0, hold_ch, hold_data[11:9]};
        tx_data[SYNC_BIT] = 1'b1;
        tx_data[HDR_BIT]  = 1'b0;
        if (tx_ready) state_nxt = ST_B1;
      end
      ST_B1: begin
        tx_data = {1'b0, hold_data[8:2]};
        if (tx_ready) state_nxt = ST_B2;
      end
      ST_B2: begin
        tx_data = {1'b0, hold_data[1:0], hold_seq};
        if (tx_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_B0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Directed bench for adc_sample_framer: single frame, enable gating,
// backpressure, reset mid-frame, overflow, full-boundary write+pop,
// clear-vs-overflow priority, and sequence wrap over 33 frames.
module tb_adc_sample_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        samp_ready;
  logic [11:0] samp_data;
  logic [2:0]  samp_ch;
  logic        tx_ready;
  logic        clr_stats;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] bytes_q [128];
  int         nbytes;

  adc_sample_framer #(
    .FIFO_DEPTH (16),
    .CNT_W      (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .samp_ready   (samp_ready),
    .samp_data    (samp_data),
    .samp_ch      (samp_ch),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .clr_stats    (clr_stats),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected frame byte b for sample (ch, d) tagged s
  function automatic logic [7:0] fb(input int b, input logic [2:0] ch,
                                    input logic [11:0] d, input logic [4:0] s);
    case (b)
      0:       return {2'b10, ch, d[11:9]};
      1:       return {1'b0, d[8:2]};
      default: return {1'b0, d[1:0], s};
    endcase
  endfunction

  task automatic strobe(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clock);
    samp_ch    = ch;
    samp_data  = d;
    samp_ready = 1'b1;
    @(negedge clock);
    samp_ready = 1'b0;
  endtask

  // Receive one frame with tx_ready=1, waiting a bounded time for each byte
  task automatic recv_frame(input string tag, input logic [2:0] ch,
                            input logic [11:0] d, input logic [4:0] s);
    for (int b = 0; b < 3; b++) begin
      int n = 0;
      while (!tx_valid && n < 40) begin
        @(negedge clock);
        n++;
      end
      chk($sformatf("%s_vld%0d", tag, b), tx_valid, 1);
      chk($sformatf("%s_byte%0d", tag, b), tx_data, fb(b, ch, d, s));
      @(negedge clock);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    samp_ready = 1'b0;
    samp_data  = '0;
    samp_ch    = '0;
    tx_ready   = 1'b0;
    clr_stats  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow_cnt, 0);
    reset = 1'b0;

    // Single sample: ch=5, 0xABC, seq 0 -> AD 2F 00
    tx_ready = 1'b1;
    strobe(3'd5, 12'hABC);
    chk("single_lat_valid", tx_valid, 0);
    chk("single_lat_level", fifo_level, 1);
    @(negedge clock);
    chk("single_valid", tx_valid, 1);
    chk("single_b0", tx_data, 8'hAD);
    chk("single_level0", fifo_level, 0);
    @(negedge clock);
    chk("single_b1", tx_data, 8'h2F);
    @(negedge clock);
    chk("single_b2", tx_data, 8'h00);
    @(negedge clock);
    chk("single_end_valid", tx_valid, 0);

    // enable=0 ignores strobes and does not advance seq
    enable = 1'b0;
    strobe(3'd3, 12'h111);
    chk("dis_level", fifo_level, 0);
    @(negedge clock);
    chk("dis_valid", tx_valid, 0);
    enable = 1'b1;

    // Backpressure in B1; this frame carries seq 1 -> AD 2F 01
    tx_ready = 1'b0;
    strobe(3'd5, 12'hABC);
    @(negedge clock);
    chk("bp_b0", tx_data, 8'hAD);
    tx_ready = 1'b1;
    @(negedge clock);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold_data%0d", i), tx_data, 8'h2F);
      chk($sformatf("bp_hold_vld%0d", i), tx_valid, 1);
      @(negedge clock);
    end
    tx_ready = 1'b1;
    chk("bp_b1", tx_data, 8'h2F);
    @(negedge clock);
    chk("bp_b2", tx_data, 8'h01);
    @(negedge clock);
    chk("bp_end_valid", tx_valid, 0);

    // Reset asserted while in B1 with two entries still buffered
    tx_ready = 1'b0;
    strobe(3'd1, 12'h0F0);
    strobe(3'd2, 12'h0F1);
    strobe(3'd3, 12'h0F2);
    tx_ready = 1'b1;
    @(negedge clock);
    tx_ready = 1'b0;
    chk("mid_b1", tx_data, 8'h3C);
    chk("mid_level", fifo_level, 2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_data", tx_data, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Overflow: 20 back-to-back strobes with no drain -> 17 kept, 3 dropped
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      samp_ch    = 3'(i % 8);
      samp_data  = 12'(i * 37 + 5);
      samp_ready = 1'b1;
      @(negedge clock);
    end
    samp_ready = 1'b0;
    chk("ovf_cnt", overflow_cnt, 3);
    chk("ovf_level", fifo_level, 16);
    chk("ovf_b0", tx_data, fb(0, 3'd0, 12'd5, 5'd0));

    // Finish frame 0; its final handshake coincides with a strobe into a full FIFO
    tx_ready = 1'b1;
    @(negedge clock);
    chk("full_b1", tx_data, fb(1, 3'd0, 12'd5, 5'd0));
    @(negedge clock);
    chk("full_b2", tx_data, fb(2, 3'd0, 12'd5, 5'd0));
    samp_ch    = 3'd7;
    samp_data  = 12'h123;
    samp_ready = 1'b1;
    @(negedge clock);
    samp_ready = 1'b0;
    tx_ready   = 1'b0;
    chk("full_wr_ovf", overflow_cnt, 3);
    chk("full_wr_level", fifo_level, 16);
    chk("full_next_b0", tx_data, fb(0, 3'd1, 12'd42, 5'd1));

    // Overflow coinciding with clear: result is 0 (this strobe, seq 21, is dropped)
    samp_ch    = 3'd6;
    samp_data  = 12'h456;
    samp_ready = 1'b1;
    clr_stats  = 1'b1;
    @(negedge clock);
    samp_ready = 1'b0;
    clr_stats  = 1'b0;
    chk("clr_wins", overflow_cnt, 0);
    chk("clr_level", fifo_level, 16);

    // Drain: frames seq 1..16, then the entry written at the full boundary (seq 20)
    tx_ready = 1'b1;
    for (int i = 1; i <= 16; i++)
      recv_frame($sformatf("drain%0d", i), 3'(i % 8), 12'(i * 37 + 5), 5'(i));
    recv_frame("drain_s20", 3'd7, 12'h123, 5'd20);
    chk("drain_idle", tx_valid, 0);
    chk("drain_level", fifo_level, 0);

    // Sequence wrap: 33 spaced strobes after a fresh reset -> 99 bytes, seq 0..31,0
    reset = 1'b1;
    @(negedge clock);
    reset  = 1'b0;
    nbytes = 0;
    fork
      begin
        for (int k = 0; k < 33; k++) begin
          strobe(3'(k % 8), 12'(k * 3 + 1));
          repeat (2) @(negedge clock);
        end
      end
      begin
        for (int c = 0; c < 33 * 4 + 30; c++) begin
          @(negedge clock);
          if (tx_valid && nbytes < 128) begin
            bytes_q[nbytes] = tx_data;
            nbytes++;
          end
        end
      end
    join
    chk("wrap_nbytes", nbytes, 99);
    for (int f = 0; f < 33 && 3 * f + 2 < nbytes; f++)
      for (int b = 0; b < 3; b++)
        chk($sformatf("wrap_f%0d_b%0d", f, b), bytes_q[3 * f + b],
            fb(b, 3'(f % 8), 12'(f * 3 + 1), 5'(f % 32)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_sample_framer.md
Name: adc_sample_framer

Overview:
- Sits directly downstream of the LTC2308 ADC reader. Consumes its one-cycle sample strobe, 12-bit sample and 3-bit channel number.
- Buffers samples in a small FIFO and serialises each one into a self-synchronising 3-byte frame, offered on a valid/ready byte stream to the UART transmitter.
- Tags every frame with a 5-bit sequence number so the host can detect dropped samples. Counts overflows.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries; power of 2, minimum 4.
- CNT_W, 16, width of the saturating overflow counter.

Ports:
- clock  in  1  system clock; same clock that drives the ADC reader.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = accept samples; 0 = ignore new strobes (buffered samples still drain).
- samp_ready  in  1  one-cycle sample strobe from the ADC reader.
- samp_data  in  12  unsigned sample; valid while samp_ready = 1.
- samp_ch  in  3  channel of the sample; valid while samp_ready = 1.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART transmitter accepts tx_data this cycle.
- clr_stats  in  1  one-cycle pulse; clears overflow_cnt.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; excludes the holding register.
- overflow_cnt  out  CNT_W  count of dropped samples; saturates at all-ones.

Behaviour:
- Reset values: tx_valid=0, tx_data=0, fifo_level=0, overflow_cnt=0, seq=0, FSM=IDLE. Reset is asynchronous: tx_valid drops immediately, including mid-frame.
- Sampling: all inputs are sampled on posedge clock.
- Strobe handling: on each edge where samp_ready & enable:
  - Form the entry {seq[4:0], samp_ch, samp_data} (20 bits).
  - If FIFO is not full, or a pop occurs on the same edge, write the entry.
  - Otherwise drop it and increment overflow_cnt (saturating).
  - seq increments on every such strobe, dropped or not, and wraps 31 -> 0.
- enable=0: strobes are ignored entirely. seq does not advance and overflow_cnt does not increment.
- clr_stats: clears overflow_cnt. If it coincides with an overflow, the clear wins and the result is 0.
- FSM states are IDLE, B0, B1, B2; tx_valid = (state != IDLE).
  - IDLE: if FIFO non-empty, pop into the holding register and go to B0. If a strobe is written at edge E into an empty FIFO, tx_valid rises at edge E+1.
  - B0: tx_data = {1'b1, 1'b0, ch[2:0], d[11:9]}. On tx_valid & tx_ready, go to B1.
  - B1: tx_data = {1'b0, d[8:2]}. On handshake, go to B2.
  - B2: tx_data = {1'b0, d[1:0], seq[4:0]}. On handshake: if FIFO non-empty, pop and go to B0 (back-to-back, no idle cycle); else go to IDLE.
- Handshake rules:
  - Byte transfer occurs only when tx_valid & tx_ready on the same edge.
  - While tx_ready=0, tx_data and tx_valid hold stable.
  - tx_ready is ignored in IDLE.
- Framing: bit 7 is set only in byte 0, so the host resyncs on bit 7.
- Capacity: FIFO_DEPTH entries plus 1 in the holding register.
- Full boundary: write and pop on the same edge when full are both honoured; level is unchanged and nothing is dropped.
- Empty boundary: pop is never issued when empty, and a write into an empty FIFO is not readable on the same edge (no bypass).
- Pointers: $clog2(FIFO_DEPTH)+1 bits, with a wrap bit to distinguish full from empty.

Decomposition:
- Package adc_frame_pkg holds:
  - FRAME_BYTES = 3, SEQ_W = 5, ENTRY_W = 20;
  - sync/header bit positions;
  - FSM state encoding.
- Sub-module sample_fifo: a synchronous single-clock FIFO with parameters WIDTH and DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data (registered on pop), full, empty, level.
  - Asynchronous active-high reset.
- Top level holds the FSM, sequence counter, overflow counter and byte mux.

Test Plan:
- Single sample: samp_ch=5, samp_data=0xABC, seq=0, tx_ready=1 -> bytes 0xAD, 0x2F, 0x00. tx_valid rises 1 cycle after the write edge and falls after the 3rd handshake.
- Backpressure: tx_ready held 0 for 10 cycles during B1 -> tx_data stays 0x2F and tx_valid stays 1. Release -> remaining bytes follow with no loss or duplication.
- Overflow (FIFO_DEPTH=16): tx_ready=0, 20 strobes -> 17 accepted (seq 0..16), overflow_cnt=3, fifo_level=16. Drain -> 17 frames, then the next strobe carries seq=20.
- Full plus simultaneous pop and write: FIFO full, handshake of B2 coincides with a strobe -> strobe accepted, overflow_cnt unchanged, fifo_level stays 16.
- Sequence wrap and back-to-back: 33 strobes with tx_ready=1 and spacing >= 3 cycles -> 99 contiguous bytes, seq runs 0..31 then 0. Bit 7 is set only on every 3rd byte.
- Reset mid-frame: assert reset during B1 -> tx_valid=0 immediately and all counters 0. After release, the next sample emits a fresh frame with seq=0.
